// File: rtl/adpll_tdc_dec_pkg.sv
// Shared constants, valid-FSM state type and helpers for the ADPLL TDC decoder.
// Optional thermometer bubble correction is enabled by defining ADPLL_TDC_BUBBLE_CORR_EN.
package adpll_tdc_dec_pkg;

  localparam int TDC_WORD_W     = 12;
  localparam int TDC_RIPPLE_W   = 7;
  localparam int TDC_PHASE_N    = 16;
  localparam int TDC_PHASE_LOG2 = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } vstate_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/adpll_tdc_therm2bin.sv
// Combinational thermometer-to-count converter with legality check.
// Under ADPLL_TDC_BUBBLE_CORR_EN a 3-tap majority filter cleans the vector before counting.
module adpll_tdc_therm2bin
  import adpll_tdc_dec_pkg::*;
#(
  parameter int PHASE_N    = TDC_PHASE_N,
  parameter int PHASE_LOG2 = TDC_PHASE_LOG2
) (
  input  logic [PHASE_N-1:0]  phase,
  output logic [PHASE_LOG2:0] count,
  output logic                bubble
);

  logic [PHASE_N-1:0] vec;

`ifdef ADPLL_TDC_BUBBLE_CORR_EN
  logic [PHASE_N+1:0] ext;

  // Virtual tap below bit0 reads 1, virtual tap above the top reads 0.
  always_comb begin
    ext = {1'b0, phase, 1'b1};
    vec = '0;
    for (int i = 0; i < PHASE_N; i++) begin
      vec[i] = maj3(ext[i], ext[i+1], ext[i+2]);
    end
  end
`else
  assign vec = phase;
`endif

  always_comb begin
    count = '0;
    for (int i = 0; i < PHASE_N; i++) begin
      count = count + {{PHASE_LOG2{1'b0}}, vec[i]};
    end
  end

  // Legality is always judged on the raw vector: a 1 sitting above a 0 is a bubble.
  always_comb begin
    bubble = 1'b0;
    for (int i = 1; i < PHASE_N; i++) begin
      bubble = bubble | (phase[i] & ~phase[i-1]);
    end
  end

endmodule

// File: rtl/adpll_tdc_dec.sv
// TDC front-end decoder: retime, thermometer decode, phase word / increment and valid FSM.
// Build option ADPLL_TDC_BUBBLE_CORR_EN selects majority bubble correction in the decode stage.
module adpll_tdc_dec
  import adpll_tdc_dec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RIPPLE_W    = TDC_RIPPLE_W,
  parameter int PHASE_N     = TDC_PHASE_N,
  parameter int PHASE_LOG2  = TDC_PHASE_LOG2,
  parameter int WORD_W      = TDC_WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     err_clr,
  input  logic [RIPPLE_W-1:0]      tdc_ripple_count,
  input  logic [PHASE_N-1:0]       tdc_phase,
  output logic [WORD_W-1:0]        tdc_word,
  output logic signed [WORD_W-1:0] tdc_diff,
  output logic                     tdc_valid,
  output logic                     bubble_err
);

  logic [SYNC_STAGES-1:0][RIPPLE_W-1:0] rip_sync;
  logic [SYNC_STAGES-1:0][PHASE_N-1:0]  ph_sync;
  logic [PHASE_LOG2:0]                  ones;
  logic                                 bad;
  logic [WORD_W-1:0]                    dec_word;
  logic                                 dec_bad;
  logic [WORD_W-1:0]                    diff_raw;
  logic [WORD_W-1:0]                    diff_wrap;
  vstate_t                              state;
  vstate_t                              state_next;
  logic                                 load;
  logic                                 first;

  // Retime chain runs regardless of en so a restart never sees stale samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rip_sync <= '0;
      ph_sync  <= '0;
    end else begin
      rip_sync[0] <= tdc_ripple_count;
      ph_sync[0]  <= tdc_phase;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rip_sync[i] <= rip_sync[i-1];
        ph_sync[i]  <= ph_sync[i-1];
      end
    end
  end

  adpll_tdc_therm2bin #(
    .PHASE_N    (PHASE_N),
    .PHASE_LOG2 (PHASE_LOG2)
  ) u_therm2bin (
    .phase  (ph_sync[SYNC_STAGES-1]),
    .count  (ones),
    .bubble (bad)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_word <= '0;
      dec_bad  <= 1'b0;
    end else begin
      dec_word <= {{(WORD_W-RIPPLE_W-PHASE_LOG2){1'b0}}, rip_sync[SYNC_STAGES-1], {PHASE_LOG2{1'b0}}}
                + {{(WORD_W-PHASE_LOG2-1){1'b0}}, ones};
      dec_bad  <= bad;
    end
  end

  // Increment is taken modulo 2**(WORD_W-1) so ripple wrap stays transparent.
  assign diff_raw  = dec_word - tdc_word;
  assign diff_wrap = {diff_raw[WORD_W-2], diff_raw[WORD_W-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE:  state_next = en ? ST_PRIME : ST_IDLE;
      ST_PRIME: state_next = en ? ST_RUN   : ST_IDLE;
      ST_RUN:   state_next = en ? ST_RUN   : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    load      = en;
    first     = (state == ST_IDLE);
    tdc_valid = (state == ST_RUN);
  end

  // The first word after enable has no predecessor, so its increment is zeroed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdc_word <= '0;
      tdc_diff <= '0;
    end else if (load) begin
      tdc_word <= dec_word;
      tdc_diff <= first ? '0 : diff_wrap;
    end else begin
      tdc_word <= tdc_word;
      tdc_diff <= tdc_diff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_err <= 1'b0;
    end else if (dec_bad) begin
      bubble_err <= 1'b1;
    end else if (err_clr) begin
      bubble_err <= 1'b0;
    end else begin
      bubble_err <= bubble_err;
    end
  end

endmodule

// File: tb/tb_adpll_tdc_dec.sv
// Self-checking bench for adpll_tdc_dec: directed scenarios plus randomized traffic
// compared against an edge-indexed behavioural model (default SYNC_STAGES=2).
module tb_adpll_tdc_dec;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               err_clr;
  logic [6:0]         ripple;
  logic [15:0]        phase;
  logic [11:0]        tdc_word;
  logic signed [11:0] tdc_diff;
  logic               tdc_valid;
  logic               bubble_err;

  int checks   = 0;
  int failures = 0;

  adpll_tdc_dec dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .err_clr          (err_clr),
    .tdc_ripple_count (ripple),
    .tdc_phase        (phase),
    .tdc_word         (tdc_word),
    .tdc_diff         (tdc_diff),
    .tdc_valid        (tdc_valid),
    .bubble_err       (bubble_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_k(input logic [15:0] p);
    int k;
    k = 0;
`ifdef ADPLL_TDC_BUBBLE_CORR_EN
    for (int i = 0; i < 16; i++) begin
      int lo, hi, s;
      lo = (i == 0)  ? 1 : int'(p[(i + 15) % 16]);
      hi = (i == 15) ? 0 : int'(p[(i + 1) % 16]);
      s  = lo + int'(p[i]) + hi;
      if (s >= 2) k++;
    end
`else
    k = $countones(p);
`endif
    return k;
  endfunction

  function automatic bit ref_bad(input logic [15:0] p);
    logic [16:0] a;
    a = {1'b0, p};
    return ((a & (a + 17'd1)) != 17'd0);
  endfunction

  function automatic int ref_word(input logic [6:0] r, input logic [15:0] p);
    return int'(r) * 16 + ref_k(p);
  endfunction

  function automatic int wrap_diff(input int cur, input int prev);
    int d;
    d = ((cur - prev) + 4096) % 2048;
    if (d >= 1024) d = d - 2048;
    return d;
  endfunction

  function automatic logic [15:0] therm(input int k);
    logic [16:0] t;
    t = (17'd1 << k) - 17'd1;
    return t[15:0];
  endfunction

  // Sample taken at edge e reaches the output stage at edge e+3.
  int  hw [8];
  bit  hb [8];
  int  ec, m_word, m_diff, m_run;
  bit  m_valid, m_err;
  int  o_word;
  bit  o_bad;

  always_comb begin
    o_word = (ec >= 3) ? hw[(ec + 5) % 8] : 0;
    o_bad  = (ec >= 3) ? hb[(ec + 5) % 8] : 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ec <= 0; m_word <= 0; m_diff <= 0; m_run <= 0; m_valid <= 1'b0; m_err <= 1'b0;
    end else begin
      hw[ec % 8] <= ref_word(ripple, phase);
      hb[ec % 8] <= ref_bad(phase);
      ec <= ec + 1;
      if (o_bad) m_err <= 1'b1;
      else if (err_clr) m_err <= 1'b0;
      if (en) begin
        m_word  <= o_word;
        m_diff  <= wrap_diff(o_word, m_word);
        m_run   <= (m_run < 2) ? m_run + 1 : 2;
        m_valid <= (m_run >= 1);
      end else begin
        m_run   <= 0;
        m_valid <= 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit e, input bit c, input logic [6:0] r, input logic [15:0] p);
    en = e; err_clr = c; ripple = r; phase = p;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 7'($urandom), 16'($urandom));
      cycle();
      checks++;
      if (tdc_word !== 12'd0 || tdc_diff !== 12'sd0 || tdc_valid !== 1'b0 || bubble_err !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs got word=%0h diff=%0d valid=%b err=%b exp all 0",
                 tdc_word, tdc_diff, tdc_valid, bubble_err);
      end
    end
    drive(1'b0, 1'b0, 7'd0, 16'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 7'($urandom), therm($urandom_range(0, 16)));
      cycle();
      checks++;
      if (tdc_valid !== 1'b0 || tdc_word !== 12'd0) begin
        failures++;
        $display("FAIL reset_en_low got valid=%b word=%0h exp valid=0 word=0", tdc_valid, tdc_word);
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, 7'd5, 16'h00FF); cycle(); end
    for (int i = 0; i < 2; i++) begin drive(1'b0, 1'b0, 7'd6, 16'h0003); cycle(); end
    drive(1'b1, 1'b0, 7'd6, 16'h0003);
    cycle();
    checks++;
    if (tdc_word !== 12'h058 || tdc_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_first got word=%0h valid=%b exp word=058 valid=0", tdc_word, tdc_valid);
    end
    cycle();
    checks++;
    if (tdc_word !== 12'h062 || tdc_diff !== 12'sd10 || tdc_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_second got word=%0h diff=%0d valid=%b exp word=062 diff=10 valid=1",
               tdc_word, tdc_diff, tdc_valid);
    end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 7'd127, 16'h00FF);
    cycle();
    for (int j = 1; j <= 4; j++) begin
      int ew, ed;
      drive(1'b1, 1'b0, 7'd1, 16'h0000);
      cycle();
      ew = (j < 3) ? 98 : ((j == 3) ? 2040 : 16);
      ed = (j < 3) ? 0  : ((j == 3) ? 1942 - 2048 : 24);
      checks++;
      if (tdc_word !== 12'(ew) || tdc_diff !== 12'(ed) || tdc_valid !== 1'b1) begin
        failures++;
        $display("FAIL wrap_step%0d got word=%0d diff=%0d valid=%b exp word=%0d diff=%0d valid=1",
                 j, tdc_word, tdc_diff, tdc_valid, ew, ed);
      end
    end
  endtask

  task automatic test_bubble();
    int exp_k;
`ifdef ADPLL_TDC_BUBBLE_CORR_EN
    exp_k = 8;
`else
    exp_k = 7;
`endif
    drive(1'b1, 1'b0, 7'd0, 16'h00F7); cycle();
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 7'd0, 16'h0001); cycle(); end
    checks++;
    if (tdc_word !== 12'(exp_k) || bubble_err !== 1'b1) begin
      failures++;
      $display("FAIL bubble_detect got word=%0d err=%b exp word=%0d err=1", tdc_word, bubble_err, exp_k);
    end
    drive(1'b1, 1'b0, 7'd0, 16'h0001); cycle();
    checks++;
    if (bubble_err !== 1'b1) begin
      failures++;
      $display("FAIL bubble_sticky got err=%b exp 1", bubble_err);
    end
    drive(1'b1, 1'b1, 7'd0, 16'h0001); cycle();
    checks++;
    if (bubble_err !== 1'b0) begin
      failures++;
      $display("FAIL bubble_clear got err=%b exp 0", bubble_err);
    end
    drive(1'b1, 1'b0, 7'd0, 16'h0100); cycle();
    for (int i = 0; i < 2; i++) begin drive(1'b1, 1'b0, 7'd0, 16'h0001); cycle(); end
    drive(1'b1, 1'b1, 7'd0, 16'h0001); cycle();
    checks++;
    if (bubble_err !== 1'b1) begin
      failures++;
      $display("FAIL bubble_set_wins got err=%b exp 1", bubble_err);
    end
    drive(1'b1, 1'b1, 7'd0, 16'h0001); cycle();
    checks++;
    if (bubble_err !== 1'b0) begin
      failures++;
      $display("FAIL bubble_clear2 got err=%b exp 0", bubble_err);
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, ($urandom_range(0, 5) == 0), 7'($urandom), 16'($urandom));
      cycle();
      checks++;
      if (bubble_err !== m_err || tdc_word !== m_word[11:0]) begin
        failures++;
        $display("FAIL bubble_rand[%0d] got err=%b word=%0d exp err=%b word=%0d",
                 i, bubble_err, tdc_word, m_err, m_word);
      end
    end
  endtask

  task automatic test_enable_gap();
    logic [11:0] hold_w;
    logic [11:0] hold_d;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 7'($urandom), therm($urandom_range(0, 16)));
      cycle();
    end
    hold_w = tdc_word;
    hold_d = tdc_diff;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 7'($urandom), therm($urandom_range(0, 16)));
      cycle();
      checks++;
      if (tdc_valid !== 1'b0 || tdc_word !== hold_w || tdc_diff !== hold_d) begin
        failures++;
        $display("FAIL gap_hold[%0d] got valid=%b word=%0d diff=%0d exp valid=0 word=%0d diff=%0d",
                 i, tdc_valid, tdc_word, tdc_diff, hold_w, $signed(hold_d));
      end
    end
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0, 7'($urandom), therm($urandom_range(0, 16)));
      cycle();
      checks++;
      if (tdc_valid !== (j >= 1) || tdc_word !== m_word[11:0]) begin
        failures++;
        $display("FAIL gap_restart[%0d] got valid=%b word=%0d exp valid=%b word=%0d",
                 j, tdc_valid, tdc_word, (j >= 1), m_word);
      end
    end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 7'd3, 16'h0000); cycle(); end
    drive(1'b1, 1'b0, 7'd9, 16'h000F);
    cycle();
    for (int j = 1; j <= 4; j++) begin
      int ew;
      drive(1'b1, 1'b0, 7'd3, 16'h0000);
      cycle();
      ew = (j == 3) ? 148 : 48;
      checks++;
      if (tdc_word !== 12'(ew)) begin
        failures++;
        $display("FAIL latency_edge%0d got word=%0d exp %0d", j, tdc_word, ew);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [15:0] p;
      p = ($urandom_range(0, 3) == 0) ? 16'($urandom) : therm($urandom_range(0, 16));
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0), 7'($urandom), p);
      if (i == 150) begin
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tdc_word !== 12'd0 || tdc_diff !== 12'sd0 || tdc_valid !== 1'b0 || bubble_err !== 1'b0) begin
          failures++;
          $display("FAIL async_reset got word=%0d diff=%0d valid=%b err=%b exp all 0",
                   tdc_word, tdc_diff, tdc_valid, bubble_err);
        end
        #1 rst = 1'b0;
      end
      cycle();
      checks++;
      if (tdc_word !== m_word[11:0] || tdc_valid !== m_valid || bubble_err !== m_err ||
          (m_valid && tdc_diff !== m_diff[11:0])) begin
        failures++;
        $display("FAIL random[%0d] got word=%0d diff=%0d valid=%b err=%b exp word=%0d diff=%0d valid=%b err=%b",
                 i, tdc_word, tdc_diff, tdc_valid, bubble_err, m_word, m_diff, m_valid, m_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 7'd0, 16'd0);
    test_reset();
    test_basic();
    test_wrap();
    test_bubble();
    test_enable_gap();
    test_latency();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
